// File: rtl/int_ctrl_if.sv
// int_ctrl_if
// Purpose : bundles the CP0-side request/response signals of int_ctrl.
// Modports:
//   slave  - the interrupt controller (takes in_* , drives out_*)
//   master - the CPU/CP0 side (drives in_*, observes out_*)
// Signals:
//   in_IRQ, in_IE, in_INM, in_EPC, in_WB_VALID, in_ERET     (to controller)
//   out_BK, out_NIE, out_REDIRECT, out_TARGET, out_SET_IE,
//   out_CAUSE, out_PEND                                      (from controller)
interface int_ctrl_if #(
  parameter int NSRC = 4
);
  logic [NSRC-1:0] in_IRQ;
  logic            in_IE;
  logic [NSRC-1:0] in_INM;
  logic [31:0]     in_EPC;
  logic            in_WB_VALID;
  logic            in_ERET;
  logic            out_BK;
  logic            out_NIE;
  logic            out_REDIRECT;
  logic [31:0]     out_TARGET;
  logic            out_SET_IE;
  logic [NSRC-1:0] out_CAUSE;
  logic [NSRC-1:0] out_PEND;

  modport slave (
    input  in_IRQ, in_IE, in_INM, in_EPC, in_WB_VALID, in_ERET,
    output out_BK, out_NIE, out_REDIRECT, out_TARGET, out_SET_IE,
           out_CAUSE, out_PEND
  );

  modport master (
    output in_IRQ, in_IE, in_INM, in_EPC, in_WB_VALID, in_ERET,
    input  out_BK, out_NIE, out_REDIRECT, out_TARGET, out_SET_IE,
           out_CAUSE, out_PEND
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl
// Purpose : request side of the CP0 exception interface. Captures rising
//           edges of the interrupt lines as pending bits, filters them with
//           INM/IE, raises the one-cycle break pulse and redirects fetch to a
//           per-source vector; on ERET redirects fetch to EPC and requests
//           IE re-enable.
// Ports:
//   in_CLK    - clock, all state on rising edge
//   in_RST_N  - synchronous active-low reset
//   bus       - int_ctrl_if.slave (see rtl/int_ctrl_if.sv)
// Build option:
//   INT_NEST_EN - when defined, an in-service register allows a
//                 higher-priority source to preempt one in service.
//
// FSM (single-level build only):
//   state     | meaning
//   S_IDLE    | no interrupt in service, a take is possible
//   S_SERVICE | an interrupt is in service, waiting for ERET
module int_ctrl #(
  parameter int          NSRC       = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic          in_CLK,
  input  logic          in_RST_N,
  int_ctrl_if.slave     bus
);

  logic [NSRC-1:0] r_irq_q;
  logic [NSRC-1:0] r_pend;

  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_elig;
  logic [NSRC-1:0] w_sel;
  logic [NSRC-1:0] w_clr;
  logic [31:0]     w_idx;
  logic            w_eret;
  logic            w_can_take;
  logic            w_take;

  assign w_rise = bus.in_IRQ & ~r_irq_q;
  assign w_elig = r_pend & ~bus.in_INM;
  // Isolate the lowest set bit: lowest index has the highest priority.
  assign w_sel  = w_elig & (~w_elig + 1'b1);

  always_comb begin
    w_idx = 32'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_idx = 32'(i);
    end
  end

  assign w_eret = in_RST_N & bus.in_WB_VALID & bus.in_ERET;

`ifdef INT_NEST_EN
  logic [NSRC-1:0] r_isr;
  logic [NSRC-1:0] w_isr_low;

  assign w_isr_low = r_isr & (~r_isr + 1'b1);
  // Both are one-hot, so a numerically smaller sel is a lower index.
  assign w_can_take = (r_isr == '0) | (w_sel < w_isr_low);
`else
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_SERVICE = 1'b1;

  logic [0:0]      r_state;
  logic [NSRC-1:0] r_cause;

  assign w_can_take = (r_state == S_IDLE);
`endif

  assign w_take = in_RST_N & w_can_take & bus.in_IE & (|w_elig) &
                  bus.in_WB_VALID & ~bus.in_ERET;
  assign w_clr  = w_take ? w_sel : '0;

  // Break/redirect are combinational so CP0 latches the retiring WB PC.
  assign bus.out_BK       = w_take;
  assign bus.out_NIE      = 1'b0;
  assign bus.out_REDIRECT = w_take | w_eret;
  assign bus.out_SET_IE   = w_eret;
  assign bus.out_TARGET   = w_eret ? bus.in_EPC :
                            w_take ? (VEC_BASE + w_idx * VEC_STRIDE) : 32'd0;
  assign bus.out_PEND     = r_pend;

  always_ff @(posedge in_CLK) begin
    if (!in_RST_N) begin
      r_irq_q <= '0;
      r_pend  <= '0;
    end else begin
      r_irq_q <= bus.in_IRQ;
      // A new rise on a bit being cleared keeps it set.
      r_pend  <= (r_pend & ~w_clr) | w_rise;
    end
  end

`ifdef INT_NEST_EN
  assign bus.out_CAUSE = w_isr_low;

  always_ff @(posedge in_CLK) begin
    if (!in_RST_N) begin
      r_isr <= '0;
    end else if (w_eret) begin
      r_isr <= r_isr & ~w_isr_low;
    end else if (w_take) begin
      r_isr <= r_isr | w_sel;
    end
  end
`else
  assign bus.out_CAUSE = r_cause;

  always_ff @(posedge in_CLK) begin
    if (!in_RST_N) begin
      r_state <= S_IDLE;
      r_cause <= '0;
    end else if (w_eret) begin
      r_state <= S_IDLE;
      r_cause <= '0;
    end else if (w_take) begin
      r_state <= S_SERVICE;
      r_cause <= w_sel;
    end
  end
`endif

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl
// Purpose : directed plus randomized checking of int_ctrl against a
//           behavioural model (pending set, in-service flag or stack of
//           in-service sources, lowest-index priority).
module tb_int_ctrl;
  localparam int NSRC = 4;

  logic in_CLK = 1'b0;
  logic in_RST_N = 1'b0;
  always #5 in_CLK = ~in_CLK;

  int_ctrl_if #(.NSRC(NSRC)) ifc ();

  int_ctrl #(
    .NSRC      (NSRC),
    .VEC_BASE  (32'h0000_0100),
    .VEC_STRIDE(32'h0000_0010)
  ) dut (
    .in_CLK  (in_CLK),
    .in_RST_N(in_RST_N),
    .bus     (ifc.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit [NSRC-1:0] m_irq_q = '0;
  bit [NSRC-1:0] m_pend  = '0;
  bit            m_busy  = 1'b0;
  bit [NSRC-1:0] m_cause = '0;
  bit [NSRC-1:0] m_isr   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input bit [NSRC-1:0] v);
    int r = -1;
    for (int i = NSRC - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic step(input bit rst_n, input bit [NSRC-1:0] irq, input bit ie,
                      input bit [NSRC-1:0] inm, input bit [31:0] epc,
                      input bit wbv, input bit eret);
    int  lo, isr_lo;
    bit  allowed, take, eret_v, e_red;
    bit [31:0] e_tgt;
    bit [NSRC-1:0] e_cause, rise, clr;
    in_RST_N        = rst_n;
    ifc.in_IRQ      = irq;
    ifc.in_IE       = ie;
    ifc.in_INM      = inm;
    ifc.in_EPC      = epc;
    ifc.in_WB_VALID = wbv;
    ifc.in_ERET     = eret;
    @(negedge in_CLK);

    lo     = lowest(m_pend & ~inm);
    isr_lo = lowest(m_isr);
`ifdef INT_NEST_EN
    allowed = (isr_lo < 0) || (lo < isr_lo);
    e_cause = (isr_lo < 0) ? '0 : NSRC'(1 << isr_lo);
`else
    allowed = !m_busy;
    e_cause = m_cause;
`endif
    eret_v = rst_n && wbv && eret;
    take   = rst_n && allowed && ie && (lo >= 0) && wbv && !eret;
    e_red  = take || eret_v;
    e_tgt  = eret_v ? epc : (take ? 32'h100 + 32'(lo) * 32'h10 : 32'h0);

    chk("BK",       32'(ifc.out_BK),       32'(take));
    chk("NIE",      32'(ifc.out_NIE),      32'd0);
    chk("REDIRECT", 32'(ifc.out_REDIRECT), 32'(e_red));
    chk("SET_IE",   32'(ifc.out_SET_IE),   32'(eret_v));
    chk("CAUSE",    32'(ifc.out_CAUSE),    32'(e_cause));
    chk("PEND",     32'(ifc.out_PEND),     32'(m_pend));
    if (e_red || !rst_n) chk("TARGET", ifc.out_TARGET, e_tgt);

    if (!rst_n) begin
      m_irq_q = '0; m_pend = '0; m_busy = 1'b0; m_cause = '0; m_isr = '0;
    end else begin
      rise    = irq & ~m_irq_q;
      clr     = take ? NSRC'(1 << lo) : '0;
      m_pend  = (m_pend & ~clr) | rise;
      m_irq_q = irq;
      if (eret_v) begin
        m_busy = 1'b0; m_cause = '0;
        if (isr_lo >= 0) m_isr[isr_lo] = 1'b0;
      end else if (take) begin
        m_busy = 1'b1; m_cause = clr; m_isr = m_isr | clr;
      end
    end
    @(posedge in_CLK);
    #1;
  endtask

  initial begin
    bit r, ie, wbv, er;
    bit [NSRC-1:0] irq, inm;
    // reset
    step(0, 4'b0000, 0, 4'b0000, 32'h0, 0, 0);
    step(0, 4'b0000, 0, 4'b0000, 32'h0, 0, 0);
    // single source 2: rise, take, in service
    step(1, 4'b0100, 1, 4'b0000, 32'h0, 0, 0);
    step(1, 4'b0100, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0100, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0000, 1, 4'b0000, 32'h40, 1, 1);
    // simultaneous 1 and 3: source 1 first, ERET, then source 3
    step(1, 4'b1010, 1, 4'b0000, 32'h0, 0, 0);
    step(1, 4'b1010, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0000, 1, 4'b0000, 32'h40, 1, 1);
    step(1, 4'b0000, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0000, 1, 4'b0000, 32'h44, 1, 1);
    // masked source 0, then unmasked
    step(1, 4'b0001, 1, 4'b0001, 32'h0, 0, 0);
    step(1, 4'b0001, 1, 4'b0001, 32'h0, 1, 0);
    step(1, 4'b0001, 1, 4'b0001, 32'h0, 1, 0);
    step(1, 4'b0001, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0000, 1, 4'b0000, 32'h50, 1, 1);
    // IE=0 holds pending; ERET without WB ignored
    step(1, 4'b1000, 0, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b1000, 0, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b1000, 1, 4'b0000, 32'h0, 0, 1);
    step(1, 4'b1000, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0000, 1, 4'b0000, 32'h60, 1, 1);
    // in service IRQ2 rises, ERET wins over take in IDLE
    step(1, 4'b1000, 1, 4'b0000, 32'h0, 0, 0);
    step(1, 4'b1000, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b1100, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b1100, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b1100, 1, 4'b0000, 32'h70, 1, 1);
    step(1, 4'b1100, 1, 4'b0000, 32'h74, 1, 1);
    step(1, 4'b1100, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0000, 1, 4'b0000, 32'h78, 1, 1);
    // reset during service with pending 0011
    step(1, 4'b0100, 1, 4'b0000, 32'h0, 0, 0);
    step(1, 4'b0100, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0111, 1, 4'b0000, 32'h0, 0, 0);
    step(0, 4'b0000, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0000, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0000, 1, 4'b0000, 32'h0, 1, 0);
    // source 2 in service, then source 0 rises (nests when enabled)
    step(1, 4'b0100, 1, 4'b0000, 32'h0, 0, 0);
    step(1, 4'b0100, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0101, 1, 4'b0000, 32'h0, 0, 0);
    step(1, 4'b0101, 1, 4'b0000, 32'h0, 1, 0);
    step(1, 4'b0000, 1, 4'b0000, 32'h80, 1, 1);
    step(1, 4'b0000, 1, 4'b0000, 32'h84, 1, 1);
    step(1, 4'b0000, 1, 4'b0000, 32'h88, 1, 1);
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      r   = ($urandom_range(0, 59) != 0);
      irq = NSRC'($urandom);
      ie  = ($urandom_range(0, 4) != 0);
      inm = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
      wbv = ($urandom_range(0, 3) != 0);
      er  = ($urandom_range(0, 5) == 0);
      step(r, irq, ie, inm, $urandom, wbv, er);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller that is the request side of the CP0 exception interface.
- Detects rising edges on external interrupt lines, holds them pending, and filters them with the CP0 mask (INM) and enable (IE).
- Raises the break pulse that makes CP0 capture EPC and clear IE, and redirects the fetch PC to a per-source vector.
- On ERET, redirects the fetch PC to EPC and requests IE re-enable.

Parameters:
- NSRC, 4, number of interrupt sources; equals INM width.
- VEC_BASE, 32'h0000_0100, vector address for source 0.
- VEC_STRIDE, 32'h0000_0010, address spacing between consecutive source vectors.

Ports:
- in_CLK  input  1  clock; all state updates on the rising edge.
- in_RST_N  input  1  reset; synchronous, active-low.
- in_IRQ  input  NSRC  raw interrupt lines, already synchronous to in_CLK.
- in_IE  input  1  CP0 interrupt enable.
- in_INM  input  NSRC  CP0 interrupt mask; bit=1 masks that source.
- in_EPC  input  32  CP0 exception PC.
- in_WB_VALID  input  1  a valid instruction retires this cycle; the interrupt may be taken on it.
- in_ERET  input  1  the retiring instruction is ERET (qualified by in_WB_VALID).
- out_BK  output  1  break pulse to CP0 in_BK.
- out_NIE  output  1  new IE value to CP0 in_NIE.
- out_REDIRECT  output  1  fetch-PC override strobe.
- out_TARGET  output  32  fetch-PC override address.
- out_SET_IE  output  1  one-cycle request to CP0 to set IE=1 (ERET).
- out_CAUSE  output  NSRC  one-hot source of the interrupt in service.
- out_PEND  output  NSRC  pending vector (debug).

Behaviour:
- Reset (in_RST_N=0 at a clock edge):
  - irq_q=0, pending=0, out_CAUSE=0, state=IDLE.
  - All combinational outputs evaluate to 0: out_BK, out_REDIRECT, out_SET_IE, out_NIE; out_TARGET=0.
  - Reset takes effect mid-service; the pending interrupt is lost.
- Edge detect:
  - irq_q registers in_IRQ.
  - rise = in_IRQ & ~irq_q.
  - pending <= (pending & ~clr) | rise.
  - A rise on the bit being cleared in the same cycle leaves that bit set (set wins).
- Eligibility:
  - elig = pending & ~in_INM, using current INM.
  - Priority is fixed; the lowest index wins. sel = one-hot lowest set bit of elig; idx = its index.
- States: IDLE, SERVICE.
- take = (state==IDLE) & in_IE & |elig & in_WB_VALID & ~in_ERET.
- Take cycle (combinational, same cycle as retire, so CP0 latches the matching WB PC):
  - out_BK=1, out_NIE=0, out_REDIRECT=1.
  - out_TARGET = VEC_BASE + idx*VEC_STRIDE (32-bit, wraps modulo 2^32).
  - At the clock edge: clr=sel, out_CAUSE<=sel, state<=SERVICE.
  - out_BK is exactly one cycle per taken interrupt.
- SERVICE:
  - No new take (non-nested build). Pending bits continue to accumulate.
- ERET (in_WB_VALID & in_ERET), any state:
  - out_REDIRECT=1, out_TARGET=in_EPC, out_SET_IE=1.
  - At the edge: state<=IDLE, out_CAUSE<=0.
  - ERET has priority over take in the same cycle.
  - ERET in IDLE still redirects to EPC and pulses out_SET_IE.
- Other cases:
  - in_ERET without in_WB_VALID is ignored.
  - in_IE=0 or all sources masked: interrupts stay pending indefinitely and are taken as soon as enabled.
- Latency: IRQ rising edge at cycle t is pending from t+1. Earliest take is cycle t+1, provided WB is valid and enabled.
- out_PEND = pending register.

Optional Feature:
- Macro: INT_NEST_EN.
- Defined:
  - An NSRC-bit in-service register isr replaces the single SERVICE state.
  - Take is allowed in any state if sel has higher priority (lower index) than every set isr bit.
  - take sets isr|=sel. ERET clears the highest-priority set isr bit.
  - out_CAUSE = that bit (the highest-priority set isr bit).
  - out_NIE=0 still; software re-enables IE for nesting.
  - CP0 holds one EPC only; saving EPC before re-enabling IE is software's responsibility.
- Undefined: single-level behaviour as above; isr logic absent.

Test Plan:
- Reset, then in_IRQ=4'b0100 rise, IE=1, INM=0, WB_VALID=1 → next cycle out_BK=1, out_NIE=0, out_TARGET=32'h120; out_CAUSE=4'b0100 and pending=0 after the edge.
- Simultaneous rises on 4'b1010 → source 1 taken first (TARGET 32'h110); after ERET with in_EPC=32'h40 → REDIRECT to 32'h40 and SET_IE=1; source 3 taken on the next valid WB cycle (TARGET 32'h130).
- INM=4'b0001, IRQ0 rises → no out_BK while masked; INM cleared → take within 1 cycle on a valid WB.
- In SERVICE, IRQ2 rises → PEND=4'b0100 and no out_BK until ERET; take and ERET presented in the same cycle → only the ERET redirect.
- in_RST_N=0 for one edge during SERVICE with pending=4'b0011 → all outputs 0 and state IDLE; no out_BK afterwards without a new edge.
- INT_NEST_EN defined: in service of source 2, IRQ0 rises with IE=1 → nested take (TARGET 32'h100); first ERET → out_CAUSE=4'b0100; second ERET → out_CAUSE=0.
